// File: rtl/xor_reduce_pkg.sv
// rtl/xor_reduce_pkg.sv - shared constants and helpers for the mux-built XOR reduction pipe
package xor_reduce_pkg;

    localparam int MAX_W = 64;
    localparam logic [MAX_W-1:0] ALL_ONES = '1;

    // Number of pairwise tree levels needed to fold n channels down to one word.
    function automatic int clog2_levels(input int n);
        int lv;
        lv = 0;
        while ((1 << lv) < n) lv++;
        return lv;
    endfunction

endpackage

// File: rtl/xor2_using_mux.sv
// rtl/xor2_using_mux.sv - W-bit two-input XOR built only from 2:1 muxes and constants
module xor2_using_mux #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    logic [W-1:0] nb;

    // Inner mux forms !b from constants; outer mux picks b or !b on a.
    always_comb begin
        nb = '0;
        y  = '0;
        for (int i = 0; i < W; i++) begin
            nb[i] = b[i] ? 1'b0 : 1'b1;
            y[i]  = a[i] ? nb[i] : b[i];
        end
    end

endmodule

// File: rtl/xor_reduce_mux_pipe.sv
// rtl/xor_reduce_mux_pipe.sv - pipelined XOR/XNOR reduction of N_CH channels with valid/ready
module xor_reduce_mux_pipe
    import xor_reduce_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                up_valid,
    output logic                up_ready,
    input  logic [N_CH*W-1:0]   up_data,
    input  logic                up_invert,
    output logic                down_valid,
    input  logic                down_ready,
    output logic [W-1:0]        down_data
);

    localparam int L = clog2_levels(N_CH);

    logic [W-1:0] in_w [N_CH];
    // All stage registers packed level after level; the final word sits at index N_CH-2.
    logic [W-1:0] q    [N_CH-1];
    logic [W-1:0] nxt  [N_CH-1];
    logic         vld  [L];
    logic         inv  [L];
    logic         rdy  [L+1];
    logic [W-1:0] q_inv;

    for (genvar c = 0; c < N_CH; c++) begin : g_in
        assign in_w[c] = up_data[c*W +: W];
    end

    assign rdy[L] = down_ready;

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int NW = N_CH >> (k + 1);
        localparam int OB = N_CH - (N_CH >> k);
        localparam int IB = OB - 2 * NW;

        logic src_vld;
        logic src_inv;

        if (k == 0) begin : g_src0
            assign src_vld = up_valid;
            assign src_inv = up_invert;
            for (genvar i = 0; i < NW; i++) begin : g_cell
                xor2_using_mux #(.W(W)) u_xor (
                    .a (in_w[2*i]),
                    .b (in_w[2*i+1]),
                    .y (nxt[OB+i])
                );
            end
        end else begin : g_srck
            assign src_vld = vld[k-1];
            assign src_inv = inv[k-1];
            for (genvar i = 0; i < NW; i++) begin : g_cell
                xor2_using_mux #(.W(W)) u_xor (
                    .a (q[IB+2*i]),
                    .b (q[IB+2*i+1]),
                    .y (nxt[OB+i])
                );
            end
        end

        // An empty stage always accepts, so bubbles collapse under a downstream stall.
        assign rdy[k] = !vld[k] || rdy[k+1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld[k] <= 1'b0;
                inv[k] <= 1'b0;
                for (int i = 0; i < NW; i++) q[OB+i] <= '0;
            end else if (rdy[k]) begin
                vld[k] <= src_vld;
                inv[k] <= src_inv;
                for (int i = 0; i < NW; i++) q[OB+i] <= nxt[OB+i];
            end
        end
    end

    xor2_using_mux #(.W(W)) u_invert (
        .a (q[N_CH-2]),
        .b (ALL_ONES[W-1:0]),
        .y (q_inv)
    );

    assign down_data  = inv[L-1] ? q_inv : q[N_CH-2];
    assign down_valid = vld[L-1];
    assign up_ready   = rdy[0];

endmodule

// File: tb/tb_xor_reduce_mux_pipe.sv
// tb/tb_xor_reduce_mux_pipe.sv - directed and random self-checking bench for xor_reduce_mux_pipe
module tb_xor_reduce_mux_pipe;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic              clk;
    logic              rst;
    logic              up_valid;
    logic              up_ready;
    logic [N_CH*W-1:0] up_data;
    logic              up_invert;
    logic              down_valid;
    logic              down_ready;
    logic [W-1:0]      down_data;

    int checks;
    int failures;
    int accepted;
    int received;
    logic [W-1:0] sb_q[$];
    logic         stall_prev;
    logic [W-1:0] held_data;

    xor_reduce_mux_pipe #(.N_CH(N_CH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_invert  (up_invert),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [N_CH*W-1:0] d, input logic iv);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < N_CH; c++) r = r ^ d[c*W +: W];
        return iv ? ~r : r;
    endfunction

    // Inputs are set at a falling edge; this samples handshakes, steps one clock, returns at the next falling edge.
    task automatic cycle();
        logic [W-1:0] e;
        #1;
        if (stall_prev) begin
            chk("stall_valid_held", down_valid, 1);
            chk("stall_data_stable", down_data, held_data);
        end
        if (down_valid && down_ready) begin
            received++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_beat", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_data", down_data, e);
            end
        end
        if (up_valid && up_ready) begin
            accepted++;
            sb_q.push_back(ref_model(up_data, up_invert));
        end
        stall_prev = down_valid && !down_ready;
        held_data  = down_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        accepted   = 0;
        received   = 0;
        stall_prev = 1'b0;
        held_data  = '0;
        rst        = 1'b0;
        up_valid   = 1'b0;
        up_data    = '0;
        up_invert  = 1'b0;
        down_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset_down_valid", down_valid, 0);
        chk("reset_down_data", down_data, 0);
        chk("reset_up_ready", up_ready, 1);
        rst = 1'b1;
        @(negedge clk);

        // Basic XOR: latency of exactly two cycles, one-cycle result.
        up_valid = 1'b1;
        up_data  = {8'h00, 8'hFF, 8'h3C, 8'hA5};
        cycle();
        up_valid = 1'b0;
        chk("xor_lat1_valid", down_valid, 0);
        cycle();
        chk("xor_valid", down_valid, 1);
        chk("xor_data", down_data, 8'h66);
        cycle();
        chk("xor_one_cycle", down_valid, 0);

        // XNOR mode on the same channels.
        up_valid  = 1'b1;
        up_invert = 1'b1;
        cycle();
        up_valid  = 1'b0;
        up_invert = 1'b0;
        cycle();
        chk("xnor_valid", down_valid, 1);
        chk("xnor_data", down_data, 8'h99);
        cycle();

        // Streaming: 16 back-to-back random beats.
        received = 0;
        for (int n = 0; n < 16; n++) begin
            up_valid  = 1'b1;
            up_data   = {$urandom, $urandom};
            up_invert = 1'($urandom_range(0, 1));
            chk("stream_up_ready", up_ready, 1);
            cycle();
        end
        up_valid = 1'b0;
        repeat (3) cycle();
        chk("stream_count", received, 16);
        chk("stream_drained", sb_q.size(), 0);

        // Backpressure: exactly two beats absorbed.
        accepted   = 0;
        received   = 0;
        down_ready = 1'b0;
        up_valid   = 1'b1;
        for (int n = 0; n < 5; n++) begin
            up_data   = {8'h11 * 8'(n + 1), 8'hC3, 8'(n), 8'h5A};
            up_invert = n[0];
            cycle();
        end
        chk("bp_accepted", accepted, 2);
        chk("bp_up_ready_low", up_ready, 0);
        up_valid   = 1'b0;
        down_ready = 1'b1;
        repeat (3) cycle();
        chk("bp_delivered", received, 2);
        chk("bp_drained", sb_q.size(), 0);

        // Random valid and ready over 1000 cycles.
        for (int n = 0; n < 1000; n++) begin
            up_valid   = 1'($urandom_range(0, 1));
            down_ready = 1'($urandom_range(0, 3) != 0);
            up_data    = {$urandom, $urandom};
            up_invert  = 1'($urandom_range(0, 1));
            cycle();
        end
        up_valid   = 1'b0;
        down_ready = 1'b1;
        repeat (4) cycle();
        chk("rand_drained", sb_q.size(), 0);

        // Asynchronous reset with two beats in flight.
        down_ready = 1'b0;
        up_valid   = 1'b1;
        up_data    = {8'h12, 8'h34, 8'h56, 8'h78};
        repeat (2) cycle();
        up_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_down_valid", down_valid, 0);
        chk("rst_mid_down_data", down_data, 0);
        chk("rst_mid_up_ready", up_ready, 1);
        sb_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        chk("rst_hold_up_ready", up_ready, 1);
        rst        = 1'b1;
        down_ready = 1'b1;
        @(negedge clk);
        up_valid  = 1'b1;
        up_invert = 1'b0;
        up_data   = {8'h08, 8'h04, 8'h02, 8'h01};
        cycle();
        up_valid = 1'b0;
        chk("rst_no_stale", down_valid, 0);
        cycle();
        chk("rst_new_valid", down_valid, 1);
        chk("rst_new_data", down_data, 8'h0F);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_reduce_mux_pipe.md
Name: xor_reduce_mux_pipe

Overview:
- Pipelined, parametrised successor to the single-gate mux-built XOR: bitwise XOR/XNOR reduction of N_CH channels, each W bits wide.
- The reduction is a binary tree of 2-input XOR cells, and every XOR cell is built only from 2:1 muxes and constants 0/1.
- Each tree level is one register stage, with valid/ready handshake and backpressure on both sides.
- Used as the parity/checksum reduction stage in datapath exercises.

Parameters:
- N_CH, 4, number of input channels; power of two, >= 2.
- W, 8, bit width of each channel and of the result.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- up_valid  input  1  upstream beat present.
- up_ready  output  1  block can accept a beat this cycle.
- up_data  input  N_CH*W  channel c occupies bits [c*W +: W].
- up_invert  input  1  1 = XNOR result; sampled with the beat.
- down_valid  output  1  result beat present.
- down_ready  input  1  downstream accepts the result.
- down_data  output  W  reduction result.

Behaviour:
- L = clog2(N_CH) pipeline stages; stage k holds N_CH>>(k+1) words of W bits, plus a valid bit and an invert sideband bit.
- Stage s0 takes pairs (2i, 2i+1) from up_data; stage sk takes pairs (2i, 2i+1) from stage k-1.
- The last stage's invert bit conditionally inverts the result. The inversion is also done with a mux cell: sel = invert, d0 = x, d1 = x XOR all-ones.
- down_valid = valid of the last stage; down_data = registered data of the last stage; there is no combinational path from up_data to down_data.
- Stage ready: ready_k = !valid_k || ready_(k+1); ready of the last stage = down_ready; up_ready = ready_0.
  - Ready is combinational back through the stages.
  - Valid does not depend combinationally on ready.
- Stage k loads when ready_k is high: valid_k <= valid_(k-1) (up_valid for k=0), and data and invert are captured.
  - When ready_k is low the stage holds data, invert and valid unchanged.
- Bubbles collapse: an empty stage always accepts, even while downstream stalls.
- Latency: a beat accepted in cycle t appears on down_valid in cycle t+L when there is no stall.
- Throughput: one beat per cycle while down_ready = 1.
- Stall: with down_ready = 0 the pipeline absorbs up to L beats, then up_ready falls.
  - No beat is dropped or duplicated.
  - down_data stays stable while down_valid = 1 and down_ready = 0.
- Simultaneous events:
  - A full pipeline with down_ready = 1 accepts a new beat in the same cycle the result leaves.
  - up_valid = 0 with a ready stage loads a bubble (valid = 0).
- Reset (rst = 0, asynchronous, any cycle including mid-stream):
  - All valid bits, data registers and invert bits clear to 0 immediately.
  - down_valid = 0, down_data = 0.
  - up_ready = 1 during and after reset.
  - Beats in flight are discarded.
- Width rule: results are exactly W bits; there is no carry or growth.
- N_CH = 2 gives a single stage and latency 1.

Decomposition:
- Package xor_reduce_pkg holds:
  - function clog2_levels(N_CH);
  - a localparam for the all-ones constant pattern.
- Sub-module xor2_using_mux (parameter W): a W-bit 2-input XOR built only from the existing mux cell and constants.
  - Per bit: y = mux(d0 = b, d1 = mux(d0 = 1, d1 = 0, sel = b), sel = a).
  - The XOR tree and the final inversion instantiate only this cell; the XOR operator is forbidden in this block.

Test Plan:
- Basic XOR, N_CH=4, W=8, down_ready=1: one beat A5, 3C, FF, 00 with up_invert=0 -> down_valid exactly 2 cycles later, down_data = 66, for 1 cycle.
- XNOR mode, same data with up_invert=1 -> down_data = 99 after 2 cycles.
- Streaming: 16 back-to-back random beats, down_ready=1 -> up_ready stays 1; 16 results in order, each matching a reference XOR/XNOR model, one per cycle.
- Backpressure: down_ready=0 while sending beats ->
  - exactly 2 beats accepted, then up_ready=0;
  - down_data stays stable;
  - releasing down_ready delivers both beats in order with no loss or duplicate.
- Random stall: random up_valid and down_ready over 1000 cycles -> the scoreboard matches every beat, and no down_data change while stalled.
- Reset mid-stream: assert rst low asynchronously between clock edges while 2 beats are in flight ->
  - down_valid=0 and down_data=00 immediately;
  - up_ready=1;
  - after release, the first new beat 01, 02, 04, 08 yields 0F with no stale output.
